// File: rtl/mem_stage.sv
// mem_stage: RISC-V MEM stage; waits for the AXI4-Lite R/B response, formats loads,
// maps error/timeout responses to access faults and drives the MEM forwarding bus.
module mem_stage #(
    parameter int         TIMEOUT_CYCLES = 0,
    parameter logic [2:0] SEL_MEM        = 3'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic [31:0] PC_EX,
    input  logic        rd_wena_EX,
    input  logic [5:0]  rd_addr_EX,
    input  logic [31:0] rd_data_EX,
    input  logic [2:0]  wb_src_EX,
    input  logic [2:0]  mem_op_EX,
    input  logic [1:0]  addr_lo_EX,
    input  logic        exc_pend_EX,
    input  logic [31:0] exc_cause_EX,
    input  logic [31:0] dmem_axi_rdata,
    input  logic [1:0]  dmem_axi_rresp,
    input  logic        dmem_axi_rvalid,
    output logic        dmem_axi_rready,
    input  logic [1:0]  dmem_axi_bresp,
    input  logic        dmem_axi_bvalid,
    output logic        dmem_axi_bready,
    output logic [31:0] PC_MEM,
    output logic        rd_wena_MEM,
    output logic [5:0]  rd_addr_MEM,
    output logic [31:0] rd_data_MEM,
    output logic        exc_pend_MEM,
    output logic [31:0] exc_cause_MEM
);
    typedef enum logic [2:0] {EMPTY, WAIT_R, WAIT_B, FULL, DRAIN_R, DRAIN_B} state_t;

    state_t      state_q;
    logic        pend_r_q, pend_b_q, wena_q, exc_q;
    logic [31:0] cnt_q, pc_q, data_q, cause_q;
    logic [5:0]  addr_q;
    logic [2:0]  op_q;
    logic [1:0]  lo_q;
    logic [31:0] byte_sh, half_sh, load_d;
    logic        is_mem, capture, to_hit;

    assign is_mem    = (wb_src_EX == SEL_MEM) && !exc_pend_EX;
    // A memory op may not issue while a timed-out response is still outstanding
    assign ready_out = !reset && !flush && (state_q == EMPTY || (state_q == FULL && ready_in))
                       && !((pend_r_q || pend_b_q) && is_mem);
    assign valid_out = (state_q == FULL) && !flush;
    assign capture   = valid_in && ready_out;
    assign to_hit    = (TIMEOUT_CYCLES > 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    assign dmem_axi_rready = state_q == WAIT_R || state_q == DRAIN_R || pend_r_q;
    assign dmem_axi_bready = state_q == WAIT_B || state_q == DRAIN_B || pend_b_q;

    assign PC_MEM        = pc_q;
    assign rd_addr_MEM   = addr_q;
    assign rd_data_MEM   = data_q;
    assign exc_pend_MEM  = exc_q;
    assign exc_cause_MEM = cause_q;
    assign rd_wena_MEM   = (state_q == FULL) && wena_q && !exc_q;

    always_comb begin
        byte_sh = dmem_axi_rdata >> {lo_q, 3'b000};
        half_sh = dmem_axi_rdata >> {lo_q[1], 4'b0000};
        load_d  = op_q[1:0] == 2'd0 ? {{24{byte_sh[7] & !op_q[2]}}, byte_sh[7:0]} :
                  op_q[1:0] == 2'd1 ? {{16{half_sh[15] & !op_q[2]}}, half_sh[15:0]} :
                  dmem_axi_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            pend_r_q <= 1'b0;
            pend_b_q <= 1'b0;
            wena_q   <= 1'b0;
            exc_q    <= 1'b0;
            cnt_q    <= '0;
            pc_q     <= '0;
            data_q   <= '0;
            cause_q  <= '0;
            addr_q   <= '0;
            op_q     <= '0;
            lo_q     <= '0;
        end else begin
            if (pend_r_q && dmem_axi_rvalid) pend_r_q <= 1'b0;
            if (pend_b_q && dmem_axi_bvalid) pend_b_q <= 1'b0;
            case (state_q)
                EMPTY, FULL: begin
                    if (capture) begin
                        pc_q    <= PC_EX;
                        addr_q  <= rd_addr_EX;
                        op_q    <= mem_op_EX;
                        lo_q    <= addr_lo_EX;
                        data_q  <= rd_data_EX;
                        exc_q   <= exc_pend_EX;
                        cause_q <= exc_pend_EX ? exc_cause_EX : 32'd0;
                        wena_q  <= rd_wena_EX && !exc_pend_EX;
                        cnt_q   <= '0;
                        state_q <= is_mem ? (rd_wena_EX ? WAIT_R : WAIT_B) : FULL;
                    end else if (flush || ready_in) begin
                        state_q <= EMPTY;
                    end
                end
                WAIT_R: begin
                    if (dmem_axi_rvalid) begin
                        state_q <= flush ? EMPTY : FULL;
                        data_q  <= load_d;
                        exc_q   <= dmem_axi_rresp[1];
                        cause_q <= dmem_axi_rresp[1] ? 32'd5 : 32'd0;
                        wena_q  <= wena_q && !dmem_axi_rresp[1];
                    end else if (flush) begin
                        state_q <= DRAIN_R;
                    end else if (to_hit) begin
                        state_q  <= FULL;
                        exc_q    <= 1'b1;
                        cause_q  <= 32'd5;
                        wena_q   <= 1'b0;
                        pend_r_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                WAIT_B: begin
                    if (dmem_axi_bvalid) begin
                        state_q <= flush ? EMPTY : FULL;
                        exc_q   <= dmem_axi_bresp[1];
                        cause_q <= dmem_axi_bresp[1] ? 32'd7 : 32'd0;
                        wena_q  <= 1'b0;
                    end else if (flush) begin
                        state_q <= DRAIN_B;
                    end else if (to_hit) begin
                        state_q  <= FULL;
                        exc_q    <= 1'b1;
                        cause_q  <= 32'd7;
                        wena_q   <= 1'b0;
                        pend_b_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                DRAIN_R: if (dmem_axi_rvalid) state_q <= EMPTY;
                DRAIN_B: if (dmem_axi_bvalid) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven vectors plus hand-written flush/timeout/back-to-back
// sequences; expected results go through a scoreboard queue popped on valid_out.
module tb_mem_stage;
    localparam logic [2:0] SEL = 3'd1;

    logic        clk = 1'b0, reset, flush, valid_in, ready_out, valid_out, ready_in;
    logic [31:0] PC_EX, rd_data_EX, exc_cause_EX, dmem_axi_rdata;
    logic        rd_wena_EX, exc_pend_EX, dmem_axi_rvalid, dmem_axi_rready;
    logic        dmem_axi_bvalid, dmem_axi_bready;
    logic [5:0]  rd_addr_EX;
    logic [2:0]  wb_src_EX, mem_op_EX;
    logic [1:0]  addr_lo_EX, dmem_axi_rresp, dmem_axi_bresp;
    logic [31:0] PC_MEM, rd_data_MEM, exc_cause_MEM;
    logic        rd_wena_MEM, exc_pend_MEM;
    logic [5:0]  rd_addr_MEM;

    mem_stage #(.TIMEOUT_CYCLES(4), .SEL_MEM(SEL)) dut (
        .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_out(ready_out),
        .valid_out(valid_out), .ready_in(ready_in), .PC_EX(PC_EX), .rd_wena_EX(rd_wena_EX),
        .rd_addr_EX(rd_addr_EX), .rd_data_EX(rd_data_EX), .wb_src_EX(wb_src_EX),
        .mem_op_EX(mem_op_EX), .addr_lo_EX(addr_lo_EX), .exc_pend_EX(exc_pend_EX),
        .exc_cause_EX(exc_cause_EX), .dmem_axi_rdata(dmem_axi_rdata),
        .dmem_axi_rresp(dmem_axi_rresp), .dmem_axi_rvalid(dmem_axi_rvalid),
        .dmem_axi_rready(dmem_axi_rready), .dmem_axi_bresp(dmem_axi_bresp),
        .dmem_axi_bvalid(dmem_axi_bvalid), .dmem_axi_bready(dmem_axi_bready),
        .PC_MEM(PC_MEM), .rd_wena_MEM(rd_wena_MEM), .rd_addr_MEM(rd_addr_MEM),
        .rd_data_MEM(rd_data_MEM), .exc_pend_MEM(exc_pend_MEM), .exc_cause_MEM(exc_cause_MEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem, store;
        logic [2:0]  op;
        logic [1:0]  lo;
        logic        exc;
        logic [31:0] cause_in, data_ex, rdata;
        logic [1:0]  resp;
        int          dly;
        logic [31:0] exp_data;
        logic        exp_wena, exp_exc;
        logic [31:0] exp_cause;
    } vec_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic        wena, exc;
        logic [31:0] cause;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tv[13];
    int   nvec = 0, nerr = 0;

    function automatic logic [31:0] pc_of(input logic [5:0] a);
        return {20'h00001, 4'h0, a, 2'b00};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] a, input logic [31:0] d, input logic w,
                        input logic x, input logic [31:0] c);
        sb.push_back(exp_t'{a, d, w, x, c});
    endtask

    task automatic drive(input logic m, input logic st, input logic [2:0] op, input logic [1:0] lo,
                         input logic ex, input logic [31:0] cause, input logic [31:0] d,
                         input logic [5:0] a);
        valid_in     = 1'b1;
        wb_src_EX    = m ? SEL : 3'd0;
        rd_wena_EX   = !st;
        mem_op_EX    = op;
        addr_lo_EX   = lo;
        exc_pend_EX  = ex;
        exc_cause_EX = cause;
        rd_data_EX   = d;
        rd_addr_EX   = a;
        PC_EX        = pc_of(a);
    endtask

    // Called #1 after a posedge with valid_in set; returns #1 after the capture edge.
    task automatic do_cap();
        int g = 0;
        while (!ready_out && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 20) begin
            nvec++; nerr++;
            $display("FAIL accept_wait: got ready_out=0 for 20 cycles, required 1");
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
    endtask

    task automatic respond(input logic st, input logic [31:0] rdata, input logic [1:0] resp,
                           input int dly);
        repeat (dly - 1) begin @(posedge clk); #1; end
        if (st) begin
            dmem_axi_bvalid = 1'b1; dmem_axi_bresp = resp;
        end else begin
            dmem_axi_rvalid = 1'b1; dmem_axi_rdata = rdata; dmem_axi_rresp = resp;
        end
        @(negedge clk);
        chk("rready_wait", dmem_axi_rready, !st);
        chk("bready_wait", dmem_axi_bready, st);
        chk("fwd_low_wait", rd_wena_MEM, 0);
        @(posedge clk); #1;
        dmem_axi_rvalid = 1'b0;
        dmem_axi_bvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL unexpected_valid: got valid_out=1 data=%h, required no output", rd_data_MEM);
            end else begin
                mon_e = sb.pop_front();
                chk("out_wena", rd_wena_MEM, mon_e.wena);
                chk("out_exc", exc_pend_MEM, mon_e.exc);
                chk("out_addr", rd_addr_MEM, mon_e.addr);
                chk("out_pc", PC_MEM, pc_of(mon_e.addr));
                if (mon_e.exc) chk("out_cause", exc_cause_MEM, mon_e.cause);
                if (mon_e.wena) chk("out_data", rd_data_MEM, mon_e.data);
            end
        end
    end

    initial begin
        int cyc, g;
        tv[0]  = '{0, 0, 3'd0, 2'd0, 0, 0, 32'h1234, 0, 2'b00, 0, 32'h1234, 1, 0, 0};
        tv[1]  = '{1, 0, 3'd0, 2'd3, 0, 0, 0, 32'h80FF0000, 2'b00, 3, 32'hFFFFFF80, 1, 0, 0};
        tv[2]  = '{1, 0, 3'd5, 2'd2, 0, 0, 0, 32'h80FF0000, 2'b00, 2, 32'h000080FF, 1, 0, 0};
        tv[3]  = '{1, 0, 3'd1, 2'd0, 0, 0, 0, 32'h12348001, 2'b00, 1, 32'hFFFF8001, 1, 0, 0};
        tv[4]  = '{1, 0, 3'd4, 2'd1, 0, 0, 0, 32'h0000A500, 2'b00, 2, 32'h000000A5, 1, 0, 0};
        tv[5]  = '{1, 0, 3'd2, 2'd0, 0, 0, 0, 32'hDEADBEEF, 2'b01, 1, 32'hDEADBEEF, 1, 0, 0};
        tv[6]  = '{1, 0, 3'd0, 2'd0, 0, 0, 0, 32'h0000007F, 2'b00, 3, 32'h0000007F, 1, 0, 0};
        tv[7]  = '{1, 0, 3'd1, 2'd2, 0, 0, 0, 32'h7FFF8000, 2'b00, 1, 32'h00007FFF, 1, 0, 0};
        tv[8]  = '{1, 1, 3'd2, 2'd0, 0, 0, 0, 0, 2'b00, 2, 0, 0, 0, 0};
        tv[9]  = '{1, 1, 3'd0, 2'd1, 0, 0, 0, 0, 2'b10, 1, 0, 0, 1, 7};
        tv[10] = '{1, 0, 3'd2, 2'd0, 0, 0, 0, 32'h5555AAAA, 2'b11, 2, 0, 0, 1, 5};
        tv[11] = '{0, 0, 3'd0, 2'd0, 1, 2, 32'h55, 0, 2'b00, 0, 0, 0, 1, 2};
        tv[12] = '{1, 0, 3'd4, 2'd3, 0, 0, 0, 32'h80FF0000, 2'b00, 1, 32'h00000080, 1, 0, 0};

        reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        PC_EX = 0; rd_data_EX = 0; exc_cause_EX = 0; rd_wena_EX = 0; exc_pend_EX = 0;
        rd_addr_EX = 0; wb_src_EX = 0; mem_op_EX = 0; addr_lo_EX = 0;
        dmem_axi_rdata = 0; dmem_axi_rresp = 0; dmem_axi_rvalid = 0;
        dmem_axi_bresp = 0; dmem_axi_bvalid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_ready_out", ready_out, 0);
        chk("rst_rready", dmem_axi_rready, 0);
        chk("rst_bready", dmem_axi_bready, 0);
        chk("rst_exc_pend", exc_pend_MEM, 0);
        chk("rst_exc_cause", exc_cause_MEM, 0);
        chk("rst_wena", rd_wena_MEM, 0);
        chk("rst_data", rd_data_MEM, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive(tv[i].mem, tv[i].store, tv[i].op, tv[i].lo, tv[i].exc, tv[i].cause_in,
                  tv[i].data_ex, 6'(i + 1));
            push(6'(i + 1), tv[i].exp_data, tv[i].exp_wena, tv[i].exp_exc, tv[i].exp_cause);
            do_cap();
            if (tv[i].mem) respond(tv[i].store, tv[i].rdata, tv[i].resp, tv[i].dly);
        end

        // Flush while waiting for R: drained, no output, then EMPTY
        @(posedge clk); #1;
        drive(1, 0, 3'd2, 2'd0, 0, 0, 0, 6'd20);
        do_cap();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("drain_ready_out", ready_out, 0);
        chk("drain_rready", dmem_axi_rready, 1);
        chk("drain_valid_out", valid_out, 0);
        @(posedge clk); #1;
        dmem_axi_rvalid = 1'b1; dmem_axi_rdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        dmem_axi_rvalid = 1'b0;
        @(negedge clk);
        chk("drain_done_ready", ready_out, 1);
        chk("drain_done_rready", dmem_axi_rready, 0);

        // Flush coinciding with the R handshake discards the response
        @(posedge clk); #1;
        drive(1, 0, 3'd2, 2'd0, 0, 0, 0, 6'd21);
        do_cap();
        flush = 1'b1; dmem_axi_rvalid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; dmem_axi_rvalid = 1'b0;
        @(negedge clk);
        chk("flush_hs_valid", valid_out, 0);
        chk("flush_hs_ready", ready_out, 1);

        // Timeout: fault after 4 waiting cycles, later load stalls until the drain
        @(posedge clk); #1;
        drive(1, 0, 3'd2, 2'd0, 0, 0, 0, 6'd22);
        push(6'd22, 0, 0, 1, 5);
        do_cap();
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            if (valid_out) break;
            cyc++;
        end
        chk("timeout_cycles", cyc, 4);
        @(posedge clk); #1;
        drive(1, 0, 3'd2, 2'd0, 0, 0, 0, 6'd23);
        push(6'd23, 32'h11223344, 1, 0, 0);
        @(negedge clk);
        chk("pend_stall", ready_out, 0);
        chk("pend_rready", dmem_axi_rready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pend_stall2", ready_out, 0);
        @(posedge clk); #1;
        dmem_axi_rvalid = 1'b1; dmem_axi_rdata = 32'hDEAD0000;
        @(posedge clk); #1;
        dmem_axi_rvalid = 1'b0;
        do_cap();
        respond(0, 32'h11223344, 2'b00, 1);

        // Back-to-back ALU ops, then a stall with ready_in low
        @(posedge clk); #1;
        drive(0, 0, 3'd0, 2'd0, 0, 0, 32'hA1, 6'd30); push(6'd30, 32'hA1, 1, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 3'd0, 2'd0, 0, 0, 32'hB2, 6'd31); push(6'd31, 32'hB2, 1, 0, 0);
        @(negedge clk);
        chk("b2b_ready_out", ready_out, 1);
        @(posedge clk); #1;
        drive(0, 0, 3'd0, 2'd0, 0, 0, 32'hC3, 6'd32); push(6'd32, 32'hC3, 1, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 3'd0, 2'd0, 0, 0, 32'hD4, 6'd33); push(6'd33, 32'hD4, 1, 0, 0);
        @(posedge clk); #1;
        ready_in = 1'b0;
        drive(0, 0, 3'd0, 2'd0, 0, 0, 32'hE5, 6'd34); push(6'd34, 32'hE5, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_valid", valid_out, 1);
            chk("stall_ready_out", ready_out, 0);
            chk("stall_data", rd_data_MEM, 32'hD4);
            chk("stall_addr", rd_addr_MEM, 6'd33);
        end
        @(posedge clk); #1;
        ready_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;

        g = 0;
        while (sb.size() != 0 && g < 50) begin
            @(posedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            nvec++; nerr++;
            $display("FAIL scoreboard_drain: got %0d results pending, required 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
